io_input_scan: RTL and testbench
================================

# io_input_scan

Scanned, debounced input-port controller for the single-cycle computer's memory-mapped input space. It samples four 32-bit external input ports round-robin on `io_clk` and debounces each port independently. It holds a committed value per port plus a sticky "changed" flag, and returns the addressed register to the CPU with one-cycle registered latency. It replaces direct port-to-bus sampling and sits between the board inputs (switches/keys) and the CPU read-data mux.

## Interface
- `STABLE_CNT`, 4: consecutive identical scan samples required to commit a port value; legal range 2..15.
- `io_clk`  in  1  I/O clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `addr`  in  32  CPU byte address; `addr[7:2]` decoded.
- `in_port0`..`in_port3`  in  32 each  raw external inputs; asynchronous to `io_clk`.
- `io_read_data`  out  32  registered read data.
- `change_irq`  out  1  high while any changed flag is set (see Configuration).

## Operation
- **Synchronizer:** each port passes through 2 flops, giving `sync[i]`.
- **Scan pointer:** a 2-bit `scan_ptr` counts 0,1,2,3,0,… and advances every cycle. Each port is visited once every 4 cycles, and only the visited port's debounce state updates.
- **Debounce per port** (state: `shadow[i]` 32b, `cnt[i]` 4b):
  - Visit with `sync[i] != shadow[i]`: `shadow <= sync`, `cnt <= 1`.
  - Visit with `sync[i] == shadow[i]` and `cnt < STABLE_CNT`: `cnt <= cnt+1`. If `cnt+1 == STABLE_CNT`, commit.
  - Visit with `cnt == STABLE_CNT`: no change; `cnt` saturates.
- **Commit:** `value[i] <= shadow[i]`. If the new value differs from the old `value[i]`, set `chg[i]`. Committing an unchanged value leaves `chg` untouched.
- **Address map** (`addr[7:2]`):
  - `110000`..`110011`: `value[0..3]`.
  - `110100`: status `{28'b0, chg[3:0]}`.
  - any other code: `32'h0`.
- **Read-clear:** every cycle whose `addr[7:2]` selects port i clears `chg[i]`. There is no read strobe, so the CPU must address input space only on real reads.
- **Simultaneous set and clear** in the same cycle on one flag: set wins.
- Reading status does not clear flags.

## Timing
- **Reset values:** `io_read_data`=0, `change_irq`=0, `scan_ptr`=0, all `shadow`/`value`/`cnt`/`chg`/synchronizer flops=0.
- **Read latency:** `io_read_data` reflects the `addr` presented in cycle n at the edge ending cycle n, i.e. 1 `io_clk`.
- **Input-to-commit latency:**
  - Stable step on `in_port[i]`: 2 cycles synchronizer, plus 0..3 cycles waiting for the visit, plus `4*(STABLE_CNT-1)` cycles.
  - With defaults this is 14..17 cycles.
- **Glitches:** any pulse shorter than one scan period (4 cycles) may be missed entirely. A pulse seen on fewer than `STABLE_CNT` consecutive visits never commits.
- **`change_irq`:** registered, asserted the cycle after a flag sets. It deasserts the cycle after the last flag clears.
- **Reset mid-debounce:** all progress is discarded and the scan restarts at port 0.

## Configuration
- `IO_INPUT_SCAN_IRQ_EN` defined: `change_irq` = registered OR of `chg[3:0]`.
- Not defined: `change_irq` tied to 0. The `chg` flags, status register and read-clear behaviour are unchanged.

## Test plan
- **Reset:** assert `resetn`=0 with `in_port0`=`32'hFFFF_FFFF`, release. Required: `io_read_data`=0 and `change_irq`=0 at the first edge. Port 0 reads `32'hFFFF_FFFF` at `addr[7:2]`=`110000` no later than 17 cycles after release.
- **Commit and flag:** hold `in_port2`=`32'h0000_00A5`. Required: status reads `32'h4` after commit; `change_irq`=1 (macro on). Read `110010`: returns `32'hA5`; status then reads 0 and `change_irq` falls the next cycle.
- **Glitch reject:** 3-cycle pulse of `32'h1` on `in_port1`. Required: `value[1]` stays 0 and status bit 1 stays 0 for 40 cycles.
- **Set/clear collision:** hold `addr[7:2]`=`110011` continuously while `in_port3` changes to `32'h7`. Required: `chg[3]` is set on the commit cycle and cleared on the following cycle; read data becomes `32'h7`.
- **Unmapped and same-value:** `addr[7:2]`=`111111` returns 0. Re-committing an identical value (bounce away for 1 visit, then back) leaves the flags at 0.
- **Macro off:** repeat the commit-and-flag scenario. Required: `change_irq` stays 0 while status still reads `32'h4`.

Source files
------------

// File: rtl/io_input_scan_if.sv
// CPU-side bus of the scanned input-port controller.
// The CPU (master) drives the byte address; the controller (slave) returns
// registered read data and the change interrupt.
interface io_input_scan_if;
  logic [31:0] addr;
  logic [31:0] io_read_data;
  logic        change_irq;

  modport master (
    output addr,
    input  io_read_data,
    input  change_irq
  );

  modport slave (
    input  addr,
    output io_read_data,
    output change_irq
  );
endinterface

// File: rtl/io_input_scan.sv
// io_input_scan: scanned, debounced controller for four 32-bit input ports.
//
// Every raw port goes through a two-flop synchronizer. A 2-bit scan pointer
// visits one port per cycle. A port's value commits after STABLE_CNT
// consecutive identical visits. A committed value that differs from the
// previous one sets a sticky changed flag. Addressing a port's value
// register clears that port's flag; a set in the same cycle wins.
//
// Optional feature macro: IO_INPUT_SCAN_IRQ_EN. When it is defined,
// change_irq is the registered OR of the changed flags. When it is not
// defined, change_irq is held at 0 and the flags still work for polling.
//
// STABLE_CNT must lie in 2..15 so that the 4-bit counters can hold it.
module io_input_scan #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic           io_clk,
  input  logic           resetn,
  io_input_scan_if.slave bus,
  input  logic [31:0]    in_port0,
  input  logic [31:0]    in_port1,
  input  logic [31:0]    in_port2,
  input  logic [31:0]    in_port3
);

  localparam int         NUM_PORTS      = 4;
  localparam logic [3:0] STABLE_C       = 4'(STABLE_CNT);
  localparam logic [5:0] ADDR_PORT_BASE = 6'b110000;
  localparam logic [5:0] ADDR_STATUS    = 6'b110100;

  logic [31:0]          in_raw    [NUM_PORTS];
  logic [31:0]          value_vec [NUM_PORTS];
  logic [NUM_PORTS-1:0] chg_vec;

  logic [1:0]  scan_ptr_reg;
  logic [31:0] io_read_data_reg;
  logic [31:0] io_read_data_next;
  logic        change_irq_reg;
  logic        change_irq_next;
  logic [5:0]  reg_sel;
  logic        unused_addr_bits;

  assign in_raw[0] = in_port0;
  assign in_raw[1] = in_port1;
  assign in_raw[2] = in_port2;
  assign in_raw[3] = in_port3;

  // Only word addresses inside one 256-byte window are decoded.
  assign reg_sel          = bus.addr[7:2];
  assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};

  // Round-robin scan pointer: visits one port every cycle and wraps.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      scan_ptr_reg <= 2'd0;
    end else begin
      scan_ptr_reg <= scan_ptr_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [31:0] sync1_reg;
      logic [31:0] sync2_reg;
      logic [31:0] shadow_reg;
      logic [31:0] shadow_next;
      logic [3:0]  cnt_reg;
      logic [3:0]  cnt_next;
      logic [31:0] value_reg;
      logic [31:0] value_next;
      logic        chg_reg;
      logic        chg_next;
      logic        visit;
      logic        commit;
      logic        read_hit;

      assign visit    = (scan_ptr_reg == 2'(gi));
      assign read_hit = (reg_sel == (ADDR_PORT_BASE + 6'(gi)));

      // Two-flop synchronizer for the asynchronous board input.
      always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
          sync1_reg <= '0;
          sync2_reg <= '0;
        end else begin
          sync1_reg <= in_raw[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Debounce step: runs only on this port's visit.
      // A new sample restarts the run. A matching sample extends the run
      // until it saturates at STABLE_CNT. The commit happens exactly once,
      // when the run length first reaches STABLE_CNT.
      always_comb begin
        shadow_next = shadow_reg;
        cnt_next    = cnt_reg;
        commit      = 1'b0;
        if (visit) begin
          if (sync2_reg != shadow_reg) begin
            shadow_next = sync2_reg;
            cnt_next    = 4'd1;
          end else if (cnt_reg < STABLE_C) begin
            cnt_next = cnt_reg + 4'd1;
            commit   = ((cnt_reg + 4'd1) == STABLE_C);
          end
        end
      end

      // Commit of the shadow into the visible value, plus the sticky flag.
      // The clear is applied first so that a set in the same cycle wins.
      always_comb begin
        value_next = value_reg;
        chg_next   = chg_reg;
        if (read_hit) begin
          chg_next = 1'b0;
        end
        if (commit) begin
          value_next = shadow_reg;
          if (shadow_reg != value_reg) begin
            chg_next = 1'b1;
          end
        end
      end

      // Per-port debounce, value and flag registers.
      always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
          shadow_reg <= '0;
          cnt_reg    <= 4'd0;
          value_reg  <= '0;
          chg_reg    <= 1'b0;
        end else begin
          shadow_reg <= shadow_next;
          cnt_reg    <= cnt_next;
          value_reg  <= value_next;
          chg_reg    <= chg_next;
        end
      end

      assign value_vec[gi] = value_reg;
      assign chg_vec[gi]   = chg_reg;
    end
  endgenerate

  // Read mux: the four value registers, the status word, zero elsewhere.
  always_comb begin
    io_read_data_next = '0;
    if (reg_sel[5:2] == ADDR_PORT_BASE[5:2]) begin
      io_read_data_next = value_vec[reg_sel[1:0]];
    end else if (reg_sel == ADDR_STATUS) begin
      io_read_data_next = {{(32-NUM_PORTS){1'b0}}, chg_vec};
    end
  end

  // Interrupt source: any pending change, or held at 0 when the feature is off.
  always_comb begin
`ifdef IO_INPUT_SCAN_IRQ_EN
    change_irq_next = |chg_vec;
`else
    change_irq_next = 1'b0;
`endif
  end

  // Registered outputs: one cycle of read latency, interrupt one cycle after the flags.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      io_read_data_reg <= '0;
      change_irq_reg   <= 1'b0;
    end else begin
      io_read_data_reg <= io_read_data_next;
      change_irq_reg   <= change_irq_next;
    end
  end

  assign bus.io_read_data = io_read_data_reg;
  assign bus.change_irq   = change_irq_reg;

endmodule

// File: tb/tb_io_input_scan.sv
// Directed testbench for io_input_scan.
// A history-based model predicts the read data and the interrupt on every
// cycle. Literal checks pin the scenarios from the test plan.
module tb_io_input_scan;

  localparam int N = 4;

`ifdef IO_INPUT_SCAN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        io_clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] in_port [4];
  logic        cmp_on = 1'b0;

  int n_vec    = 0;
  int n_miscmp = 0;

  io_input_scan_if bus_if ();

  io_input_scan #(.STABLE_CNT(N)) dut (
    .io_clk   (io_clk),
    .resetn   (resetn),
    .bus      (bus_if),
    .in_port0 (in_port[0]),
    .in_port1 (in_port[1]),
    .in_port2 (in_port[2]),
    .in_port3 (in_port[3])
  );

  always #5 io_clk = ~io_clk;

  // ---------------- behavioural model ----------------
  // Each port keeps the samples taken on its last N+1 visits. A value
  // commits on the visit at which it has been seen on exactly N
  // consecutive visits.
  logic [31:0] m_in_d1 [4];
  logic [31:0] m_in_d2 [4];
  logic [31:0] m_hist  [4][N+1];
  int          m_len   [4];
  logic [31:0] m_val   [4];
  logic [3:0]  m_chg;
  int          m_cycle;
  logic [31:0] m_rd;
  logic        m_irq;

  function automatic logic [31:0] read_map(input logic [31:0] a);
    logic [5:0] w;
    w = a[7:2];
    if (w >= 6'h30 && w <= 6'h33) return m_val[w - 6'h30];
    if (w == 6'h34)               return {28'b0, m_chg};
    return 32'h0;
  endfunction

  always @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        m_in_d1[i] = '0;
        m_in_d2[i] = '0;
        m_len[i]   = 0;
        m_val[i]   = '0;
        for (int k = 0; k <= N; k++) m_hist[i][k] = '0;
      end
      m_chg   = '0;
      m_cycle = 0;
      m_rd    = '0;
      m_irq   = 1'b0;
    end else begin
      int          p;
      logic [31:0] s;
      bit          run_ok;
      bit          fresh;
      logic [3:0]  set_m;
      logic [3:0]  clr_m;
      // outputs reflect the state that is valid before this edge
      m_rd  = read_map(bus_if.addr);
      m_irq = IRQ_EN && (m_chg != 4'b0);
      // visit of one port, round-robin from port 0 after reset
      p = m_cycle % 4;
      s = m_in_d2[p];
      for (int k = 0; k < N; k++) m_hist[p][k] = m_hist[p][k+1];
      m_hist[p][N] = s;
      if (m_len[p] < N + 1) m_len[p]++;
      run_ok = (m_len[p] >= N);
      for (int k = 1; k <= N; k++) if (m_hist[p][k] != s) run_ok = 0;
      fresh = (m_len[p] == N) || (m_hist[p][0] != s);
      set_m = '0;
      if (run_ok && fresh) begin
        if (m_val[p] != s) set_m[p] = 1'b1;
        m_val[p] = s;
      end
      clr_m = '0;
      for (int i = 0; i < 4; i++)
        if (bus_if.addr[7:2] == 6'(6'h30 + i)) clr_m[i] = 1'b1;
      m_chg = (m_chg & ~clr_m) | set_m;
      // two-stage delay of the raw inputs
      for (int i = 0; i < 4; i++) begin
        m_in_d2[i] = m_in_d1[i];
        m_in_d1[i] = in_port[i];
      end
      m_cycle++;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(negedge io_clk) begin
    #1;
    if (cmp_on) begin
      n_vec++;
      if (bus_if.io_read_data !== m_rd) begin
        n_miscmp++;
        $display("FAIL cyc_read_data t=%0t: got %h, required %h", $time, bus_if.io_read_data, m_rd);
      end
      n_vec++;
      if (bus_if.change_irq !== m_irq) begin
        n_miscmp++;
        $display("FAIL cyc_change_irq t=%0t: got %b, required %b", $time, bus_if.change_irq, m_irq);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic wait_rd(input logic [31:0] want, input int bound, output int took);
    took = 0;
    while (bus_if.io_read_data !== want && took < bound) begin
      @(negedge io_clk);
      took++;
    end
  endtask

  initial begin
    int took;
    int bad;
    for (int i = 0; i < 4; i++) in_port[i] = '0;
    bus_if.addr = 32'h0;

    // Reset with port 0 all ones.
    #2;
    resetn     = 1'b0;
    cmp_on     = 1'b1;
    in_port[0] = 32'hFFFF_FFFF;
    repeat (3) @(negedge io_clk);
    bus_if.addr = 32'h0000_00C0;
    resetn      = 1'b1;
    @(negedge io_clk);
    check("reset_read_data", bus_if.io_read_data, 32'h0);
    check("reset_change_irq", {31'b0, bus_if.change_irq}, 32'h0);
    wait_rd(32'hFFFF_FFFF, 30, took);
    check("reset_port0_value", bus_if.io_read_data, 32'hFFFF_FFFF);
    // commit by edge 17 after release, visible through the read register one edge later
    n_vec++;
    if (1 + took > 18) begin
      n_miscmp++;
      $display("FAIL reset_commit_latency: got %0d edges, required <= 18", 1 + took);
    end

    // Commit and flag on port 2.
    @(negedge io_clk);
    bus_if.addr = 32'h0000_00D0;
    in_port[2]  = 32'h0000_00A5;
    wait_rd(32'h4, 30, took);
    check("commit_status", bus_if.io_read_data, 32'h4);
    check("commit_irq", {31'b0, bus_if.change_irq}, {31'b0, IRQ_EN});
    bus_if.addr = 32'h0000_00C8;
    @(negedge io_clk);
    check("commit_read_value", bus_if.io_read_data, 32'h0000_00A5);
    bus_if.addr = 32'h0000_00D0;
    @(negedge io_clk);
    check("commit_status_cleared", bus_if.io_read_data, 32'h0);
    check("commit_irq_fell", {31'b0, bus_if.change_irq}, 32'h0);

    // Glitch rejection: 3-cycle pulse on port 1.
    in_port[1] = 32'h1;
    repeat (3) @(negedge io_clk);
    in_port[1] = 32'h0;
    bad = 0;
    repeat (40) begin
      @(negedge io_clk);
      if (bus_if.io_read_data[1] !== 1'b0) bad++;
    end
    check("glitch_status_bit1_cycles", bad, 0);
    bus_if.addr = 32'h0000_00C4;
    @(negedge io_clk);
    @(negedge io_clk);
    check("glitch_value1", bus_if.io_read_data, 32'h0);

    // Set/clear collision on port 3 while its value register is addressed.
    bus_if.addr = 32'h0000_00CC;
    in_port[3]  = 32'h7;
    wait_rd(32'h7, 30, took);
    check("collision_value", bus_if.io_read_data, 32'h7);
    check("collision_irq_pulse", {31'b0, bus_if.change_irq}, {31'b0, IRQ_EN});
    bus_if.addr = 32'h0000_00D0;
    @(negedge io_clk);
    check("collision_status_cleared", bus_if.io_read_data, 32'h0);

    // Unmapped code and upper address bits ignored.
    bus_if.addr = 32'h0000_00FC;
    @(negedge io_clk);
    check("unmapped_read", bus_if.io_read_data, 32'h0);
    bus_if.addr = 32'h1234_56C0;
    @(negedge io_clk);
    check("upper_bits_ignored", bus_if.io_read_data, 32'hFFFF_FFFF);

    // Same-value recommit: port 2 bounces to 0 for one visit, then back.
    bus_if.addr = 32'h0000_00D0;
    in_port[2]  = 32'h0;
    repeat (4) @(negedge io_clk);
    in_port[2] = 32'h0000_00A5;
    bad = 0;
    repeat (30) begin
      @(negedge io_clk);
      if (bus_if.io_read_data !== 32'h0) bad++;
    end
    check("same_value_status_cycles", bad, 0);
    bus_if.addr = 32'h0000_00C8;
    @(negedge io_clk);
    @(negedge io_clk);
    check("same_value_port2", bus_if.io_read_data, 32'h0000_00A5);

    // Reset in the middle of a debounce run on port 1.
    in_port[1] = 32'h0000_0055;
    repeat (8) @(negedge io_clk);
    resetn = 1'b0;
    #2;
    check("midreset_read_data", bus_if.io_read_data, 32'h0);
    check("midreset_irq", {31'b0, bus_if.change_irq}, 32'h0);
    @(negedge io_clk);
    bus_if.addr = 32'h0000_00C4;
    resetn      = 1'b1;
    wait_rd(32'h0000_0055, 30, took);
    check("midreset_port1_value", bus_if.io_read_data, 32'h0000_0055);
    repeat (4) @(negedge io_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  // Watchdog: the scenarios above are short; anything past this is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
